// File: rtl/tile_accum_binarize.sv
// Accumulates TILE_CNT partial vectors per output, then emits saturated and binarized results.
// Optional saturation tracking (sat_flag, sat_cnt) is built when TILE_ACCUM_SAT_FLAG_EN is defined.
module tile_accum_binarize #(
  parameter int OUT_DIM  = 4,
  parameter int BIT_CNT  = 8,
  parameter int TILE_CNT = 4,
  parameter int ACC_W    = BIT_CNT + $clog2(TILE_CNT) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [OUT_DIM-1:0][BIT_CNT-1:0]   in_data,
  input  logic [OUT_DIM-1:0][ACC_W-1:0]     thresh,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_DIM-1:0][BIT_CNT-1:0]   out_sat,
  output logic [OUT_DIM-1:0]                out_bin
`ifdef TILE_ACCUM_SAT_FLAG_EN
  ,
  output logic [OUT_DIM-1:0]                sat_flag,
  output logic [15:0]                       sat_cnt
`endif
);

  // state | meaning
  // ACCUM | accepting tiles, summing into acc
  // EMIT  | result held on out_sat/out_bin until consumer handshake
  typedef enum logic {ACCUM, EMIT} state_t;

  localparam int CNT_W = (TILE_CNT > 1) ? $clog2(TILE_CNT) : 1;
  localparam logic [CNT_W-1:0] LAST_TILE = CNT_W'(TILE_CNT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-BIT_CNT+1){1'b0}}, {(BIT_CNT-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-BIT_CNT+1){1'b1}}, {(BIT_CNT-1){1'b0}}};

  state_t                           state;
  logic [CNT_W-1:0]                 tile_cnt;
  logic signed [ACC_W-1:0]          acc [OUT_DIM];
  logic signed [ACC_W-1:0]          sum [OUT_DIM];
  logic [OUT_DIM-1:0][BIT_CNT-1:0]  sat_nxt;
  logic [OUT_DIM-1:0]               bin_nxt;
  logic [OUT_DIM-1:0]               hi_clip;
  logic [OUT_DIM-1:0]               lo_clip;
  logic                             accept;
  logic                             last_tile;

  assign accept    = in_valid && in_ready && (state == ACCUM);
  assign last_tile = (tile_cnt == LAST_TILE);

  // Final sum includes the tile being accepted this cycle
  always_comb begin
    for (int i = 0; i < OUT_DIM; i++) begin
      sum[i]     = acc[i] + $signed({{(ACC_W-BIT_CNT){in_data[i][BIT_CNT-1]}}, in_data[i]});
      hi_clip[i] = (sum[i] > SAT_MAX);
      lo_clip[i] = (sum[i] < SAT_MIN);
      if (hi_clip[i])
        sat_nxt[i] = SAT_MAX[BIT_CNT-1:0];
      else if (lo_clip[i])
        sat_nxt[i] = SAT_MIN[BIT_CNT-1:0];
      else
        sat_nxt[i] = sum[i][BIT_CNT-1:0];
      bin_nxt[i] = (sum[i] >= $signed(thresh[i]));
    end
  end

`ifdef TILE_ACCUM_SAT_FLAG_EN
  logic [15:0] flag_cnt;

  always_comb begin
    flag_cnt = '0;
    for (int i = 0; i < OUT_DIM; i++)
      flag_cnt = flag_cnt + 16'(sat_flag[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= '0;
      sat_cnt  <= '0;
    end else if (clear) begin
      sat_cnt <= '0;
    end else if (accept && last_tile) begin
      sat_flag <= hi_clip | lo_clip;
    end else if (state == EMIT && out_ready) begin
      sat_cnt <= sat_cnt + flag_cnt;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      tile_cnt  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sat   <= '0;
      out_bin   <= '0;
      for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
    end else if (clear) begin
      state     <= ACCUM;
      tile_cnt  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
    end else begin
      case (state)
        ACCUM: begin
          in_ready <= 1'b1;
          if (accept) begin
            for (int i = 0; i < OUT_DIM; i++) acc[i] <= sum[i];
            if (last_tile) begin
              tile_cnt  <= '0;
              out_sat   <= sat_nxt;
              out_bin   <= bin_nxt;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= EMIT;
            end else begin
              tile_cnt <= tile_cnt + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_accum_binarize.sv
// Directed bench for tile_accum_binarize with an integer reference model checked every cycle.
module tb_tile_accum_binarize;
  localparam int OUT_DIM  = 4;
  localparam int BIT_CNT  = 8;
  localparam int TILE_CNT = 4;
  localparam int ACC_W    = 11;

  logic                              clk = 1'b0;
  logic                              rst_n = 1'b0;
  logic                              clear = 1'b0;
  logic                              in_valid = 1'b0;
  logic                              in_ready;
  logic [OUT_DIM-1:0][BIT_CNT-1:0]   in_data = '0;
  logic [OUT_DIM-1:0][ACC_W-1:0]     thresh = '0;
  logic                              out_valid;
  logic                              out_ready = 1'b1;
  logic [OUT_DIM-1:0][BIT_CNT-1:0]   out_sat;
  logic [OUT_DIM-1:0]                out_bin;
`ifdef TILE_ACCUM_SAT_FLAG_EN
  logic [OUT_DIM-1:0]                sat_flag;
  logic [15:0]                       sat_cnt;
`endif

  tile_accum_binarize #(.OUT_DIM(OUT_DIM), .BIT_CNT(BIT_CNT), .TILE_CNT(TILE_CNT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .thresh(thresh), .out_valid(out_valid), .out_ready(out_ready),
    .out_sat(out_sat), .out_bin(out_bin)
`ifdef TILE_ACCUM_SAT_FLAG_EN
    , .sat_flag(sat_flag), .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer sums per channel, clamp and compare by arithmetic
  int                               m_acc [OUT_DIM] = '{default: 0};
  int                               m_tiles = 0;
  logic                             m_valid = 1'b0;
  logic                             m_ready = 1'b0;
  logic                             m_fresh = 1'b1;
  logic [OUT_DIM-1:0][BIT_CNT-1:0]  m_sat = '0;
  logic [OUT_DIM-1:0]               m_bin = '0;
  logic [OUT_DIM-1:0]               m_flag = '0;
  int                               m_scnt = 0;

  function automatic int clamp(input int s);
    if (s > 127) return 127;
    if (s < -128) return -128;
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = '{default: 0}; m_tiles = 0; m_valid = 0; m_ready = 0;
      m_fresh = 1; m_sat = '0; m_bin = '0; m_flag = '0; m_scnt = 0;
    end else if (clear) begin
      m_acc = '{default: 0}; m_tiles = 0; m_valid = 0; m_ready = 1; m_scnt = 0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 0;
        m_ready = 1;
        for (int i = 0; i < OUT_DIM; i++) m_scnt += int'(m_flag[i]);
      end
    end else begin
      if (in_valid && m_ready) begin
        for (int i = 0; i < OUT_DIM; i++) m_acc[i] += int'($signed(in_data[i]));
        m_tiles++;
        if (m_tiles == TILE_CNT) begin
          for (int i = 0; i < OUT_DIM; i++) begin
            m_sat[i]  = 8'(clamp(m_acc[i]));
            m_flag[i] = (clamp(m_acc[i]) != m_acc[i]);
            m_bin[i]  = (m_acc[i] >= int'($signed(thresh[i])));
          end
          m_acc = '{default: 0};
          m_tiles = 0;
          m_valid = 1;
          m_fresh = 0;
        end
      end
      m_ready = !m_valid;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid || m_fresh) begin
      chk("out_sat", 64'(out_sat), 64'(m_sat));
      chk("out_bin", 64'(out_bin), 64'(m_bin));
    end
`ifdef TILE_ACCUM_SAT_FLAG_EN
    if (m_valid) chk("sat_flag", 64'(sat_flag), 64'(m_flag));
    chk("sat_cnt", 64'(sat_cnt), 64'(m_scnt));
`endif
  end

  task automatic send_tile(input logic [31:0] d);
    int n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      n_vec++; n_err++;
      $display("FAIL valid_timeout actual=out_valid_low required=out_valid_high");
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic accumulate: 4 x 10 -> 40
    for (int t = 0; t < 4; t++) send_tile({4{8'd10}});
    idle();
    wait_valid();
    chk("basic_sat", 64'(out_sat), 64'h28282828);
    chk("basic_bin", 64'(out_bin), 64'hf);
    chk("basic_ready", 64'(in_ready), 64'h0);
    @(negedge clk);

    // Saturation in both directions
    send_tile({8'h00, 8'h64, 8'h80, 8'h7f});
    send_tile({8'h00, 8'h9c, 8'h80, 8'h7f});
    send_tile({8'h00, 8'h05, 8'h80, 8'h7f});
    send_tile({8'h00, 8'h00, 8'h80, 8'h7f});
    idle();
    wait_valid();
    chk("satur_sat", 64'(out_sat), 64'h0005807f);
    chk("satur_bin", 64'(out_bin), 64'hd);
`ifdef TILE_ACCUM_SAT_FLAG_EN
    chk("satur_flag", 64'(sat_flag), 64'h3);
    @(negedge clk);
    chk("satur_cnt", 64'(sat_cnt), 64'd2);
`else
    @(negedge clk);
`endif

    // Threshold equality: ch0 -3 vs -3, ch1 -4 vs -3
    thresh[0] = 11'h7fd;
    thresh[1] = 11'h7fd;
    for (int t = 0; t < 3; t++) send_tile({8'h00, 8'h00, 8'hff, 8'hff});
    send_tile({8'h00, 8'h00, 8'hff, 8'h00});
    idle();
    wait_valid();
    chk("thr_bin", 64'(out_bin), 64'hd);
    chk("thr_sat", 64'(out_sat), 64'h0000fcfd);
    thresh = '0;
    @(negedge clk);

    // Backpressure with in_valid held high
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) send_tile({4{8'd20}});
    @(negedge clk);
    in_data = {4{8'd99}};
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 64'(out_valid), 64'h1);
      chk("bp_sat", 64'(out_sat), 64'h50505050);
      chk("bp_ready", 64'(in_ready), 64'h0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) send_tile({4{8'd3}});
    idle();
    wait_valid();
    chk("bp_next_sat", 64'(out_sat), 64'h0c0c0c0c);
    @(negedge clk);

    // clear drops the concurrent tile and the partial sum
    send_tile({4{8'd50}});
    send_tile({4{8'd50}});
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {4{8'd50}};
    clear    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int t = 0; t < 4; t++) send_tile({4{8'd1}});
    idle();
    wait_valid();
    chk("clr_sat", 64'(out_sat), 64'h04040404);
    @(negedge clk);

    // Async reset during EMIT
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) send_tile({4{8'd7}});
    idle();
    wait_valid();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'h0);
    chk("arst_sat", 64'(out_sat), 64'h0);
    chk("arst_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) send_tile({4{8'd7}});
    idle();
    chk("arst_partial", 64'(out_valid), 64'h0);
    send_tile({4{8'd7}});
    idle();
    wait_valid();
    chk("arst_sat_new", 64'(out_sat), 64'h1c1c1c1c);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
